// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: receives a framed, XOR-checksummed image and
// writes it into instruction/data memory, holding the CPU in reset until done.
module uart_boot_loader #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned ADDR_WIDTH   = 13,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic                  sysclk,
  input  logic                  rst,
  input  logic                  uart_rx,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_data,
  output logic [3:0]            mem_we,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned      CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN0  = 3'd1;
  localparam logic [2:0] ST_LEN1  = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_CSUM  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;
  localparam logic [2:0] ST_ERROR = 3'd6;

  logic [1:0]            sync_q;
  logic                  rx_prev_q;
  logic                  rx_s;

  logic [1:0]            rx_state_q, rx_state_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic [2:0]            rx_bit_q, rx_bit_d;
  logic [7:0]            rx_shift_q, rx_shift_d;
  logic                  byte_valid_c;
  logic                  frame_err_c;

  logic [2:0]            state_q, state_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] word_idx_q, word_idx_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [31:0]           word_q, word_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_data_q, mem_data_d;
  logic [3:0]            mem_we_q, mem_we_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  assign rx_s = sync_q[1];

  // State register for synchronizer, receiver and loader FSM
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      sync_q     <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      state_q    <= ST_IDLE;
      len_q      <= '0;
      csum_q     <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      word_q     <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      mem_we_q   <= '0;
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], uart_rx};
      rx_prev_q  <= rx_s;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      state_q    <= state_d;
      len_q      <= len_d;
      csum_q     <= csum_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      word_q     <= word_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      mem_we_q   <= mem_we_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
    end
  end

  // Bit-level receiver; returns to idle right after the stop sample so a
  // start bit immediately following the stop bit is caught
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    byte_valid_c = 1'b0;
    frame_err_c  = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_s) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_M1) begin
          rx_cnt_d = '0;
          rx_bit_d = '0;
          rx_state_d = rx_s ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_s, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == FULL_M1) begin
          rx_cnt_d     = '0;
          rx_state_d   = RX_IDLE;
          byte_valid_c = rx_s;
          frame_err_c  = !rx_s;
        end else begin
          rx_cnt_d = rx_cnt_q + CNT_W'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Frame parser, memory write generation and status outputs
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    csum_d     = csum_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    mem_we_d   = 4'h0;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    case (state_q)
      ST_IDLE: begin
        if (byte_valid_c && rx_shift_q == SYNC_BYTE) begin
          state_d = ST_LEN0;
          csum_d  = '0;
        end
      end
      ST_LEN0: begin
        if (byte_valid_c) begin
          len_d[7:0] = rx_shift_q;
          csum_d     = csum_q ^ rx_shift_q;
          state_d    = ST_LEN1;
        end
      end
      ST_LEN1: begin
        if (byte_valid_c) begin
          len_d  = {rx_shift_q, len_q[7:0]};
          csum_d = csum_q ^ rx_shift_q;
          if (33'({rx_shift_q, len_q[7:0]}) > (33'(1) << ADDR_WIDTH)) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end else if ({rx_shift_q, len_q[7:0]} == 16'd0) begin
            state_d = ST_CSUM;
          end else begin
            state_d    = ST_DATA;
            word_idx_d = '0;
            byte_idx_d = '0;
          end
        end
      end
      ST_DATA: begin
        if (byte_valid_c) begin
          csum_d = csum_q ^ rx_shift_q;
          word_d[{byte_idx_q, 3'b000} +: 8] = rx_shift_q;
          if (byte_idx_q == 2'd3) begin
            mem_we_d   = 4'hF;
            mem_addr_d = word_idx_q;
            mem_data_d = {rx_shift_q, word_q[23:0]};
            byte_idx_d = '0;
            if (32'(word_idx_q) == 32'(len_q) - 32'd1) begin
              state_d = ST_CSUM;
            end else begin
              word_idx_d = word_idx_q + ADDR_WIDTH'(1);
            end
          end else begin
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid_c) begin
          if (rx_shift_q == csum_q) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            state_d = ST_ERROR;
            error_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done_d     = 1'b1;
        cpu_hold_d = 1'b0;
      end
      ST_ERROR: begin
        cpu_hold_d = 1'b1;
        if (byte_valid_c && rx_shift_q == SYNC_BYTE) begin
          state_d = ST_LEN0;
          csum_d  = '0;
          error_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Bad stop bit aborts any frame in progress; idle line noise and a
    // finished load are left alone
    if (frame_err_c && state_q != ST_IDLE && state_q != ST_DONE) begin
      state_d    = ST_ERROR;
      error_d    = 1'b1;
      cpu_hold_d = 1'b1;
    end
  end

  assign mem_addr = mem_addr_q;
  assign mem_data = mem_data_q;
  assign mem_we   = mem_we_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Serial program loader that sits upstream of the CPU's unified instruction/data memory. It receives a framed program image over a UART line (8N1) and writes it word-by-word into memory through a write port. It holds the CPU in reset until a complete, checksum-verified image has been written. After a successful load it releases the CPU and goes quiet until the next reset.

## Interface
Parameters:
- CLKS_PER_BIT, 868: sysclk cycles per UART bit (100 MHz / 115200); must be ≥ 8.
- ADDR_WIDTH, 13: memory word-address width; the maximum image is 2^ADDR_WIDTH words.
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- sysclk  in  1  system clock; all state on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- uart_rx  in  1  serial input; idles high; asynchronous to sysclk.
- mem_addr  out  ADDR_WIDTH  word address of the current write.
- mem_data  out  32  write data, little-endian assembled.
- mem_we  out  4  byte write enables; 4'b1111 for a write cycle, else 4'b0000.
- cpu_hold  out  1  1 = keep CPU in reset.
- done  out  1  image loaded and verified; sticky.
- error  out  1  framing, length or checksum failure; sticky until a retry or reset.

## Operation
- Reset values: mem_addr=0, mem_data=0, mem_we=0, cpu_hold=1, done=0, error=0, FSM=IDLE, checksum=0.
- RX front end:
  - uart_rx passes through a 2-flop synchronizer.
  - A synchronized falling edge while idle starts a byte.
  - The start bit is re-checked at CLKS_PER_BIT/2. If it is high, the start is treated as a glitch and the receiver returns to idle with no error.
  - 8 data bits are then sampled LSB-first at mid-bit, followed by the stop bit.
  - A stop bit of 1 produces a one-cycle internal byte_valid. A stop bit of 0 is a framing error.
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI, then LEN words of 4 bytes each (byte0 is least significant), then CSUM. CSUM is the XOR of LEN_LO, LEN_HI and every data byte.
- FSM states: IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR.
  - IDLE: bytes other than SYNC_BYTE are ignored. SYNC_BYTE moves to LEN0 and clears checksum.
  - LEN0: stores LEN_LO, moves to LEN1.
  - LEN1: stores LEN_HI.
    - If LEN > 2^ADDR_WIDTH, go to ERROR.
    - If LEN == 0, go to CSUM.
    - Otherwise go to DATA with word index 0 and byte index 0.
  - DATA: shifts each byte into its lane. On byte index 3, pulse mem_we=4'b1111 with mem_addr=word index and mem_data=the assembled word. After the last word, go to CSUM.
  - CSUM: a byte equal to the running checksum goes to DONE. Any other value goes to ERROR.
  - DONE: done=1 and cpu_hold=0. All further RX activity is ignored until reset.
  - ERROR: error=1 and cpu_hold=1. A SYNC_BYTE received here clears error and enters LEN0 (retry).
- A framing error in any state other than IDLE or DONE goes to ERROR. A framing error in IDLE is ignored.
- Words already written before an error are not rolled back. A retry overwrites them.

## Timing
- byte_valid asserts 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT cycles after the uart_rx falling edge (±1 for synchronizer phase).
- The FSM acts on byte_valid in the same cycle, so mem_we is registered and high for exactly the one cycle after byte_valid of byte3. mem_addr and mem_data are valid in that same cycle and hold until the next write.
- done and cpu_hold change together, one cycle after byte_valid of a matching CSUM byte.
- error rises one cycle after the offending byte_valid or stop-bit sample.
- Back-to-back bytes with zero idle gap must be accepted: the receiver re-arms in the cycle after the stop sample.
- Asserting rst at any point, including mid-byte or mid-write, immediately forces all reset values; a pending write is dropped.
- Maximum word index: 2^ADDR_WIDTH−1. The index never wraps because LEN is bounded at LEN1.

## Test plan
- CLKS_PER_BIT=16; send A5 02 00 | 78 56 34 12 | EF BE AD DE | CSUM=0xAC^... (computed by bench) -> writes (0,0x12345678), (1,0xDEADBEEF), one mem_we cycle each; done=1 and cpu_hold=0 one cycle after CSUM.
- Send garbage 00 FF 3C before A5 01 00 11 22 33 44 CSUM -> garbage ignored; a single write (0,0x44332211); done=1.
- A correct frame with CSUM off by 1 -> error=1, cpu_hold=1, done=0. Then resend the correct frame -> error clears on A5; done=1.
- ADDR_WIDTH=4, LEN=17 -> error=1 after LEN_HI, no writes. LEN=0 with CSUM=0x00 -> done=1, no writes.
- Stop bit forced low on the 2nd data byte -> error=1. A 1-cycle low glitch on idle uart_rx -> no byte, no error.
- Pull rst low midway through word 1 -> all outputs return to reset values asynchronously. A subsequent full frame loads correctly.
